score_combo_tracker: RTL and testbench

Game-side scoring engine that consumes the 2-bit game state and the combo-display enable from the state generator, and produces the `combo` pulse the state generator takes as input.
- Counts hits and misses from the player buttons.
- Maintains a BCD score, the current streak and the best streak.
- Drives a registered 4-digit BCD word for the 7-segment driver, showing score or streak/best as selected by `display_combo_en`.

---
 rtl/score_combo_tracker_if.sv | 24 ++
 rtl/score_combo_tracker.sv | 166 ++++++++++++++++
 tb/tb_score_combo_tracker.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/score_combo_tracker_if.sv
// Signal bundle between the game state generator and the scoring engine.
// master = state generator side, slave = score_combo_tracker.
interface score_combo_tracker_if;
    logic [1:0]  game_state;
    logic        display_combo_en;
    logic        hit;
    logic        miss;
    logic        combo;
    logic [15:0] score_bcd;
    logic [7:0]  streak_bcd;
    logic [7:0]  best_bcd;
    logic [15:0] disp_bcd;
    logic        score_sat;

    modport master (
        output game_state, display_combo_en, hit, miss,
        input  combo, score_bcd, streak_bcd, best_bcd, disp_bcd, score_sat
    );

    modport slave (
        input  game_state, display_combo_en, hit, miss,
        output combo, score_bcd, streak_bcd, best_bcd, disp_bcd, score_sat
    );
endinterface

// File: rtl/score_combo_tracker.sv
// BCD scoring engine: hit/miss edge counting, score, streak, best streak, combo pulse.
// Optional macro MISS_PENALTY_EN: a miss in RUN also subtracts 1 from the score (floored at 0).
module score_combo_tracker #(
    parameter int unsigned COMBO_THRESH = 5,
    parameter int unsigned BONUS_PTS    = 2
) (
    input logic clk,
    input logic rst_n,
    score_combo_tracker_if.slave bus
);
    typedef enum logic [1:0] {MODE_RUN, MODE_PAUSE, MODE_CLEAR} mode_t;

    localparam logic [6:0] MOD_LAST  = 7'(COMBO_THRESH - 1);
    localparam logic [6:0] THRESH_7  = 7'(COMBO_THRESH);
    localparam logic [3:0] BONUS_4   = 4'(BONUS_PTS);

    logic        hit_q, miss_q;
    logic [15:0] score, score_n;
    logic [7:0]  streak, streak_n;
    logic [7:0]  best, best_n;
    logic [6:0]  mod_cnt, mod_n;
    logic        sat, sat_n;
    logic        combo_r, combo_n;
    logic [15:0] disp;
    logic        hit_ev, miss_ev;
    logic [6:0]  streak_bin;
    logic [3:0]  hit_pts;
    logic [16:0] sum;
    mode_t       mode;

    // Returns {carry_out, a + b} with BCD digit carry; b is a single digit.
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [3:0] b);
        logic [15:0] r;
        logic [4:0]  s;
        logic        c;
        r = '0;
        s = {1'b0, a[3:0]} + {1'b0, b};
        c = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i != 0) s = {1'b0, a[i*4 +: 4]} + {4'd0, c};
            if (s > 5'd9) begin
                r[i*4 +: 4] = 4'(s - 5'd10);
                c = 1'b1;
            end else begin
                r[i*4 +: 4] = s[3:0];
                c = 1'b0;
            end
        end
        return {c, r};
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] a);
        logic [15:0] r;
        logic        b;
        r = a;
        b = 1'b1;
        if (a != '0) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (b) begin
                    if (a[i*4 +: 4] == 4'd0) begin
                        r[i*4 +: 4] = 4'd9;
                    end else begin
                        r[i*4 +: 4] = a[i*4 +: 4] - 4'd1;
                        b = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc2(input logic [7:0] a);
        if (a[3:0] == 4'd9) return {a[7:4] + 4'd1, 4'd0};
        return {a[7:4], a[3:0] + 4'd1};
    endfunction

    always_comb begin
        case (bus.game_state)
            2'd0:    mode = MODE_RUN;
            2'd2:    mode = MODE_CLEAR;
            default: mode = MODE_PAUSE;
        endcase
    end

    assign hit_ev     = bus.hit  & ~hit_q;
    assign miss_ev    = bus.miss & ~miss_q;
    assign streak_bin = 7'(streak[7:4]) * 7'd10 + 7'(streak[3:0]);
    assign hit_pts    = (streak_bin >= THRESH_7) ? BONUS_4 : 4'd1;
    assign sum        = bcd_add(score, hit_pts);

    always_comb begin
        score_n  = score;
        streak_n = streak;
        best_n   = best;
        sat_n    = sat;
        mod_n    = mod_cnt;
        combo_n  = 1'b0;
        case (mode)
            MODE_CLEAR: begin
                score_n  = '0;
                streak_n = '0;
                sat_n    = 1'b0;
                mod_n    = '0;
            end
            MODE_RUN: begin
                if (miss_ev) begin
                    streak_n = '0;
                    mod_n    = '0;
`ifdef MISS_PENALTY_EN
                    score_n  = bcd_dec(score);
`endif
                end else if (hit_ev) begin
                    if (sum[16]) begin
                        score_n = 16'h9999;
                        sat_n   = 1'b1;
                    end else begin
                        score_n = sum[15:0];
                    end
                    // Streak and modulo counter freeze together at 99.
                    if (streak != 8'h99) begin
                        streak_n = bcd_inc2(streak);
                        if (mod_cnt == MOD_LAST) begin
                            mod_n   = '0;
                            combo_n = 1'b1;
                        end else begin
                            mod_n = mod_cnt + 7'd1;
                        end
                    end
                    if (streak_n > best) best_n = streak_n;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            score   <= '0;
            streak  <= '0;
            best    <= '0;
            mod_cnt <= '0;
            sat     <= 1'b0;
            combo_r <= 1'b0;
            disp    <= '0;
        end else begin
            hit_q   <= bus.hit;
            miss_q  <= bus.miss;
            score   <= score_n;
            streak  <= streak_n;
            best    <= best_n;
            mod_cnt <= mod_n;
            sat     <= sat_n;
            combo_r <= combo_n;
            disp    <= bus.display_combo_en ? {streak, best} : score;
        end
    end

    assign bus.combo      = combo_r;
    assign bus.score_bcd  = score;
    assign bus.streak_bcd = streak;
    assign bus.best_bcd   = best;
    assign bus.score_sat  = sat;
    assign bus.disp_bcd   = disp;
endmodule

// File: tb/tb_score_combo_tracker.sv
// Directed bench for score_combo_tracker: a binary-integer reference model pushes
// expected outputs into a queue each cycle; they are popped and asserted after the edge.
module tb_score_combo_tracker;
    localparam int TH = 5;
    localparam int BP = 2;

    typedef struct {
        logic [15:0] score;
        logic [7:0]  streak;
        logic [7:0]  best;
        logic        combo;
        logic        sat;
        logic [15:0] disp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    score_combo_tracker_if bus();

    score_combo_tracker #(.COMBO_THRESH(TH), .BONUS_PTS(BP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail = 0;
    exp_t sb[$];

    int m_score, m_streak, m_best;
    bit m_sat, m_hq, m_mq;
    logic [15:0] m_disp;

    function automatic logic [15:0] bcd4(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic model_step(output exp_t e);
        bit eh, em, c;
        int pts;
        c = 1'b0;
        if (!rst_n) begin
            m_score = 0; m_streak = 0; m_best = 0; m_sat = 0;
            m_hq = 0; m_mq = 0; m_disp = '0;
        end else begin
            eh = bus.hit && !m_hq;
            em = bus.miss && !m_mq;
            m_hq = bus.hit;
            m_mq = bus.miss;
            m_disp = bus.display_combo_en ? {bcd2(m_streak), bcd2(m_best)} : bcd4(m_score);
            if (bus.game_state == 2'd2) begin
                m_score = 0; m_streak = 0; m_sat = 0;
            end else if (bus.game_state == 2'd0) begin
                if (em) begin
                    m_streak = 0;
`ifdef MISS_PENALTY_EN
                    if (m_score > 0) m_score--;
`endif
                end else if (eh) begin
                    pts = (m_streak >= TH) ? BP : 1;
                    if (m_score + pts > 9999) begin
                        m_score = 9999;
                        m_sat = 1;
                    end else begin
                        m_score += pts;
                    end
                    if (m_streak < 99) begin
                        m_streak++;
                        if (m_streak % TH == 0) c = 1'b1;
                    end
                    if (m_streak > m_best) m_best = m_streak;
                end
            end
        end
        e.score = bcd4(m_score);
        e.streak = bcd2(m_streak);
        e.best = bcd2(m_best);
        e.combo = c;
        e.sat = m_sat;
        e.disp = m_disp;
    endtask

    task automatic tick(input string tag);
        exp_t e;
        model_step(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".score"}, bus.score_bcd, e.score);
        check({tag, ".streak"}, 16'(bus.streak_bcd), 16'(e.streak));
        check({tag, ".best"}, 16'(bus.best_bcd), 16'(e.best));
        check({tag, ".combo"}, 16'(bus.combo), 16'(e.combo));
        check({tag, ".sat"}, 16'(bus.score_sat), 16'(e.sat));
        check({tag, ".disp"}, bus.disp_bcd, e.disp);
    endtask

    task automatic hit_pulse(input string tag);
        bus.hit = 1'b1; tick(tag);
        bus.hit = 1'b0; tick(tag);
    endtask

    task automatic miss_pulse(input string tag);
        bus.miss = 1'b1; tick(tag);
        bus.miss = 1'b0; tick(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.hit = 1'b0; bus.miss = 1'b0;
        bus.game_state = 2'd0; bus.display_combo_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.hit = ~bus.hit;
            tick("rst");
        end
        bus.hit = 1'b0;
        rst_n = 1'b1;
        tick("rst_rel");
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        bit ok;
        bus.hit = 1'b0; bus.miss = 1'b0;
        bus.game_state = 2'd0; bus.display_combo_en = 1'b0;
        #3;

        // 1: reset with hit toggling, then first hit
        do_reset();
        check("t1.reset_score", bus.score_bcd, 16'h0000);
        bus.hit = 1'b1; tick("t1");
        check("t1.score", bus.score_bcd, 16'h0001);
        check("t1.streak", 16'(bus.streak_bcd), 16'h01);
        check("t1.best", 16'(bus.best_bcd), 16'h01);
        bus.hit = 1'b0; tick("t1");

        // 2: six hits from zero, combo on fifth
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            bus.hit = 1'b1; tick("t2");
            check("t2.combo_at_event", 16'(bus.combo), (i == 5) ? 16'd1 : 16'd0);
            bus.hit = 1'b0; tick("t2");
        end
        check("t2.score", bus.score_bcd, 16'h0007);
        check("t2.streak", 16'(bus.streak_bcd), 16'h06);

        // 3: held hit counts once, also across pause -> run
        base = m_score;
        bus.hit = 1'b1;
        repeat (20) tick("t3_hold");
        bus.game_state = 2'd1; repeat (3) tick("t3_pause");
        bus.game_state = 2'd3; repeat (2) tick("t3_pause3");
        bus.game_state = 2'd0; repeat (3) tick("t3_run");
        bus.hit = 1'b0; tick("t3");
        check("t3.single_count", bus.score_bcd, bcd4(base + BP));
        check("t3.streak", 16'(bus.streak_bcd), 16'h07);

        // 4: simultaneous hit and miss, miss wins
        miss_pulse("t4_miss");
        repeat (7) hit_pulse("t4_build");
        base = m_score;
        bus.hit = 1'b1; bus.miss = 1'b1; tick("t4_both");
        check("t4.streak", 16'(bus.streak_bcd), 16'h00);
        check("t4.combo", 16'(bus.combo), 16'd0);
        check("t4.best", 16'(bus.best_bcd), 16'h07);
`ifdef MISS_PENALTY_EN
        check("t4.score", bus.score_bcd, bcd4(base - 1));
`else
        check("t4.score", bus.score_bcd, bcd4(base));
`endif
        bus.hit = 1'b0; bus.miss = 1'b0; tick("t4");

        // 6: display mux, streak 12 / best 15
        do_reset();
        repeat (15) hit_pulse("t6_best");
        miss_pulse("t6_miss");
        repeat (12) hit_pulse("t6_streak");
        bus.display_combo_en = 1'b1; tick("t6_disp");
        check("t6.disp", bus.disp_bcd, 16'h1215);
        bus.display_combo_en = 1'b0; tick("t6_disp_off");
        check("t6.disp_score", bus.disp_bcd, bus.score_bcd);
`ifdef MISS_PENALTY_EN
        bus.game_state = 2'd2; tick("t6_clear");
        bus.game_state = 2'd0;
        miss_pulse("t6_floor");
        check("t6.floor", bus.score_bcd, 16'h0000);
`endif

        // 5: preload to 9998 with streak >= TH, then a bonus hit saturates
        ok = 1'b0;
        for (int j = 0; j <= TH && !ok; j++) begin
            bus.game_state = 2'd2; tick("t5_clear");
            bus.game_state = 2'd0;
            repeat (j) hit_pulse("t5_align");
            miss_pulse("t5_align");
            while (m_streak < TH) hit_pulse("t5_align");
            ok = ((9998 - m_score) % BP == 0);
        end
        for (int k = 0; k < 6000 && m_score < 9998; k++) hit_pulse("t5_fill");
        check("t5.preload", bus.score_bcd, 16'h9998);
        check("t5.presat", 16'(bus.score_sat), 16'd0);
        hit_pulse("t5_bonus");
        check("t5.sat_score", bus.score_bcd, 16'h9999);
        check("t5.sat_flag", 16'(bus.score_sat), 16'd1);
        hit_pulse("t5_more");
        check("t5.sat_hold", bus.score_bcd, 16'h9999);
        bus.game_state = 2'd2; tick("t5_clear");
        check("t5.clr_score", bus.score_bcd, 16'h0000);
        check("t5.clr_sat", 16'(bus.score_sat), 16'd0);
        check("t5.best_kept", 16'(bus.best_bcd), 16'h99);
        bus.game_state = 2'd0; tick("t5_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
